// File: rtl/sync_word_rx.sv
// sync_word_rx
//
// Receive side of a 2-phase (toggle) request/acknowledge handshake. It brings
// a multi-bit word from an asynchronous source into the clk_i domain.
// Only the request toggle passes through a synchroniser. The word is sampled
// straight from data_async_i once the synchronised toggle has been seen. At
// that point the source is guaranteed to hold the word stable until ack_o
// toggles. The captured word is then offered downstream with valid/ready.
//
// Ports:
//   clk_i         system clock
//   rst_in        asynchronous active-low reset
//   req_async_i   request toggle from the source (one level change = one word)
//   data_async_i  source data, stable from its req toggle until ack_o toggles
//   ack_o         acknowledge toggle back to the source (registered)
//   en_i          capture enable; a detected request waits while low
//   data_o        captured word (registered)
//   valid_o       data_o is valid
//   ready_i       downstream accepts data_o
//   busy_o        request pending or word valid (registered with the state)
//   overrun_o     sticky flag: request toggle arrived while still busy
//   clr_i         synchronous clear of overrun_o (a new overrun wins)
module sync_word_rx #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,   // must be 2 or more
  parameter logic [WIDTH-1:0] INIT_VAL    = '0
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             req_async_i,
  input  logic [WIDTH-1:0] data_async_i,
  output logic             ack_o,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  input  logic             clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_prev_q, req_prev_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [WIDTH-1:0]       data_q, data_d;

  logic req_s;
  logic req_edge;
  logic overrun_set;

  assign req_s    = sync_q[SYNC_STAGES-1];
  // Any level change of the synchronised request is one new word.
  assign req_edge = req_s ^ req_prev_q;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], req_async_i};
    req_prev_d  = req_s;
    state_d     = state_q;
    ack_d       = ack_q;
    valid_d     = valid_q;
    data_d      = data_q;
    overrun_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_edge) begin
          if (en_i) begin
            data_d  = data_async_i;
            valid_d = 1'b1;
            state_d = VALID;
          end else begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // A second toggle here is a source protocol error. It is flagged
        // and dropped, and the first request still completes normally.
        overrun_set = req_edge;
        if (en_i) begin
          data_d  = data_async_i;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        overrun_set = req_edge;
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // If a new overrun and a clear land on the same edge, the set wins.
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      data_q     <= INIT_VAL;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_prev_q <= req_prev_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      data_q     <= data_d;
    end
  end

  assign ack_o     = ack_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;
  assign data_o    = data_q;

endmodule

// File: tb/tb_sync_word_rx.sv
// Bench for sync_word_rx. Stimulus pushes each expected accepted word into a
// scoreboard queue. A monitor pops it and compares data_o whenever
// valid_o && ready_i. Timing, handshake and flag behaviour are checked
// directly by the stimulus process, using hand-computed edge counts.
module tb_sync_word_rx;
  localparam int          W     = 32;
  localparam logic [W-1:0] INITV = 32'hA5A5_0F0F;

  logic         clk_i = 1'b0;
  logic         rst_in;
  logic         req_async_i;
  logic [W-1:0] data_async_i;
  logic         ack_o;
  logic         en_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic         busy_o;
  logic         overrun_o;
  logic         clr_i;

  sync_word_rx #(.WIDTH(W), .SYNC_STAGES(2), .INIT_VAL(INITV)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .req_async_i(req_async_i),
    .data_async_i(data_async_i), .ack_o(ack_o), .en_i(en_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .clr_i(clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int  ack_cnt  = 0;
  logic ack_prev = 1'b0;
  logic ack_exp  = 1'b0;
  bit  b2b_done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Scoreboard monitor: one pop per accepted word.
  always @(negedge clk_i) begin
    if (rst_in === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", {32'b0, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_data", {32'b0, data_o}, {32'b0, e});
        $display("[TB] word accepted %h (expected %h)", data_o, e);
      end
    end
    if (ack_o !== ack_prev) ack_cnt++;
    ack_prev = ack_o;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(logic [W-1:0] d);
    data_async_i = d;
    req_async_i  = ~req_async_i;
  endtask

  initial begin
    int base;
    rst_in = 1'b0; req_async_i = 1'b0; data_async_i = '0;
    en_i = 1'b1; ready_i = 1'b1; clr_i = 1'b0;
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, INITV);
    chk("rst_ack", ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst_in = 1'b1;
    tick(2);

    // 1: basic latency, ready already high
    exp_q.push_back(32'hDEADBEEF);
    send(32'hDEADBEEF);
    tick(2);
    chk("t1_valid_early", valid_o, 0);
    tick(1);
    chk("t1_valid", valid_o, 1);
    chk("t1_data", data_o, 32'hDEADBEEF);
    tick(1);
    ack_exp = ~ack_exp;
    chk("t1_valid_drop", valid_o, 0);
    chk("t1_ack", ack_o, ack_exp);
    $display("[TB] t1 basic transfer done");
    tick(3);

    // 2: ready low for 5 cycles
    ready_i = 1'b0;
    exp_q.push_back(32'h12345678);
    send(32'h12345678);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", valid_o, 1);
      chk("t2_hold_data", data_o, 32'h12345678);
      chk("t2_hold_ack", ack_o, ack_exp);
      if (i < 4) tick(1);
    end
    ready_i = 1'b1;
    tick(1);
    ack_exp = ~ack_exp;
    chk("t2_valid_drop", valid_o, 0);
    chk("t2_ack", ack_o, ack_exp);
    $display("[TB] t2 backpressure done");
    tick(3);

    // 3: en_i low holds the request pending
    en_i = 1'b0;
    send(32'hCAFEF00D);
    tick(3);
    for (int i = 0; i < 10; i++) begin
      chk("t3_pend_busy", busy_o, 1);
      chk("t3_pend_valid", valid_o, 0);
      tick(1);
    end
    data_async_i = 32'h0BADC0DE;
    exp_q.push_back(32'h0BADC0DE);
    en_i = 1'b1;
    tick(1);
    chk("t3_valid", valid_o, 1);
    chk("t3_data", data_o, 32'h0BADC0DE);
    tick(1);
    ack_exp = ~ack_exp;
    chk("t3_valid_drop", valid_o, 0);
    chk("t3_ack", ack_o, ack_exp);
    $display("[TB] t3 enable gating done");
    tick(3);

    // 4: overrun, clear, and set-wins-over-clear
    ready_i = 1'b0;
    exp_q.push_back(32'h11111111);
    send(32'h11111111);
    tick(3);
    chk("t4_valid", valid_o, 1);
    send(32'h22222222);
    tick(3);
    chk("t4_overrun", overrun_o, 1);
    chk("t4_data_kept", data_o, 32'h11111111);
    chk("t4_valid_kept", valid_o, 1);
    ready_i = 1'b1;
    tick(1);
    ack_exp = ~ack_exp;
    chk("t4_ack", ack_o, ack_exp);
    tick(6);
    chk("t4_single_ack", ack_o, ack_exp);
    chk("t4_idle_valid", valid_o, 0);
    chk("t4_idle_busy", busy_o, 0);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    chk("t4_clr", overrun_o, 0);
    ready_i = 1'b0;
    exp_q.push_back(32'h33333333);
    send(32'h33333333);
    tick(3);
    chk("t4b_valid", valid_o, 1);
    send(32'h44444444);
    clr_i = 1'b1;
    tick(3);
    clr_i = 1'b0;
    chk("t4b_set_wins", overrun_o, 1);
    chk("t4b_data_kept", data_o, 32'h33333333);
    ready_i = 1'b1;
    tick(1);
    ack_exp = ~ack_exp;
    chk("t4b_ack", ack_o, ack_exp);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    chk("t4b_clr", overrun_o, 0);
    $display("[TB] t4 overrun done");
    tick(3);

    // 5: 100 back-to-back words, random ready_i
    base = ack_cnt;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic a0;
          int   waited;
          logic [W-1:0] w;
          w = 32'h1000_0000 + i * 32'h0101_0101;
          exp_q.push_back(w);
          a0 = ack_o;
          send(w);
          waited = 0;
          tick(1);
          while (ack_o === a0 && waited < 200) begin
            tick(1);
            waited++;
          end
          if (ack_o === a0) begin
            n_tests++; n_fail++;
            $display("FAIL t5_ack_timeout: word %0d got no ack, expected toggle", i);
          end
        end
        b2b_done = 1'b1;
      end
      begin
        while (!b2b_done) begin
          tick(1);
          ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    ready_i = 1'b1;
    tick(2);
    ack_exp = ack_o;
    chk("t5_ack_count", ack_cnt - base, 100);
    chk("t5_overrun", overrun_o, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    $display("[TB] t5 back-to-back done");

    // 6: asynchronous reset while VALID
    ready_i = 1'b0;
    send(32'h55555555);
    tick(3);
    chk("t6_valid", valid_o, 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_data", data_o, INITV);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ack", ack_o, 0);
    req_async_i = 1'b0;
    tick(1);
    rst_in = 1'b1;
    tick(5);
    chk("t6_idle_busy", busy_o, 0);
    chk("t6_idle_valid", valid_o, 0);
    chk("t6_idle_ack", ack_o, 0);
    $display("[TB] t6 async reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
